mc_main_controller: RTL and testbench

//  Multicycle RV32I control FSM; drives the 2-bit selects of the datapath mux4 instances (ALUSrcA, ALUSrcB,

---
 rtl/mc_ctrl_pkg.sv | 62 ++++++
 rtl/mc_alu_decoder.sv | 33 +++
 rtl/mc_main_controller.sv | 194 +++++++++++++++++++
 tb/tb_mc_main_controller.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// ALU operation codes and the datapath mux select values.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ = 3'b000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUIWB    = 4'd11
  } state_e;

  // ALU operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALURES = 2'd2;
  localparam logic [1:0] RES_IMM    = 2'd3;

  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_OLDPC = 2'd1;
  localparam logic [1:0] A_REGA  = 2'd2;

  localparam logic [1:0] B_REGB = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode: maps operation class plus funct3/funct7b5
// to an ALU operation, flagging funct3 values the datapath does not implement.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_r_i,
  output logic [2:0] alu_ctl_o,
  output logic       bad_f3_o
);

  always_comb begin
    alu_ctl_o = ALU_ADD;
    bad_f3_o  = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_ctl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7b5 only selects sub for register-register ops; addi ignores it
          3'b000:  alu_ctl_o = (is_r_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctl_o = ALU_SLT;
          3'b110:  alu_ctl_o = ALU_OR;
          3'b111:  alu_ctl_o = ALU_AND;
          default: bad_f3_o  = 1'b1;
        endcase
      end
      default: alu_ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle RV32I control FSM driving datapath selects and write enables.
// Optional MC_BNE_EN: BRANCH with funct3==001 takes the branch when zero is low.
module mc_main_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTL_W  = 3,
  parameter int IMM_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [IMM_SEL_W-1:0] imm_src,
  output logic [ALUCTL_W-1:0]  alu_ctl,
  output logic                 reg_write,
  output logic                 illegal
);

  state_e     state_q, state_d;
  logic       alu_bad_q, alu_bad_d;
  alu_op_e    alu_op;
  logic       is_r;
  logic [2:0] alu_ctl_w;
  logic       bad_f3;

  logic       pcw_c, adr_c, mw_c, irw_c, rw_c, ill_c;
  logic [1:0] res_c, a_c, b_c;
  logic [2:0] imm_c;

  assign is_r = (state_q == S_EXECR);

  always_comb begin
    case (state_q)
      S_EXECR, S_EXECI: alu_op = ALUOP_FUNCT;
      S_BRANCH:         alu_op = ALUOP_SUB;
      default:          alu_op = ALUOP_ADD;
    endcase
  end

  mc_alu_decoder u_alu_dec (
    .alu_op_i   (alu_op),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .is_r_i     (is_r),
    .alu_ctl_o  (alu_ctl_w),
    .bad_f3_o   (bad_f3)
  );

  // Remember an unsupported funct3 so the following ALUWB skips its write
  assign alu_bad_d = ((state_q == S_EXECR) || (state_q == S_EXECI)) && bad_f3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      alu_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_bad_q <= alu_bad_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    pcw_c   = 1'b0;
    adr_c   = 1'b0;
    mw_c    = 1'b0;
    irw_c   = 1'b0;
    rw_c    = 1'b0;
    ill_c   = 1'b0;
    res_c   = RES_ALUOUT;
    a_c     = A_PC;
    b_c     = B_REGB;
    imm_c   = IMM_I;
    case (state_q)
      S_FETCH: begin
        irw_c   = 1'b1;
        pcw_c   = 1'b1;
        b_c     = B_FOUR;
        res_c   = RES_ALURES;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_c   = A_OLDPC;
        b_c   = B_IMM;
        imm_c = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_OP:             state_d = S_EXECR;
          OP_OPIMM:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUIWB;
          default: begin
            ill_c   = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        a_c     = A_REGA;
        b_c     = B_IMM;
        imm_c   = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_c   = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_c = RES_DATA;
        rw_c  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_c = 1'b1;
        mw_c  = 1'b1;
      end
      S_EXECR: begin
        a_c     = A_REGA;
        ill_c   = bad_f3;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        a_c     = A_REGA;
        b_c     = B_IMM;
        ill_c   = bad_f3;
        state_d = S_ALUWB;
      end
      S_ALUWB: rw_c = ~alu_bad_q;
      S_BRANCH: begin
        a_c = A_REGA;
        if (funct3 == F3_BEQ) begin
          pcw_c = zero;
`ifdef MC_BNE_EN
        end else if (funct3 == 3'b001) begin
          pcw_c = ~zero;
`endif
        end else begin
          ill_c = 1'b1;
        end
      end
      S_JAL: begin
        a_c     = A_OLDPC;
        b_c     = B_FOUR;
        imm_c   = IMM_J;
        pcw_c   = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUIWB: begin
        res_c = RES_IMM;
        imm_c = IMM_U;
        rw_c  = 1'b1;
      end
      default: ill_c = 1'b1;
    endcase
  end

  // Reset holds every enable and select low, independent of the state
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'd0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    imm_src    = '0;
    alu_ctl    = '0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      pc_write   = pcw_c;
      adr_src    = adr_c;
      mem_write  = mw_c;
      ir_write   = irw_c;
      result_src = res_c;
      alu_src_a  = a_c;
      alu_src_b  = b_c;
      imm_src    = IMM_SEL_W'(imm_c);
      alu_ctl    = ALUCTL_W'(alu_ctl_w);
      reg_write  = rw_c;
      illegal    = ill_c;
    end
  end

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed bench for mc_main_controller: walks each instruction class cycle by
// cycle and compares the packed control word against hand-derived values.
module tb_mc_main_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_ctl;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_main_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .alu_ctl    (alu_ctl),
    .reg_write  (reg_write),
    .illegal    (illegal)
  );

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, imm_src, alu_ctl, reg_write, illegal}
  logic [17:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_ctl, reg_write, illegal};

  function automatic logic [17:0] ev(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] res,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [2:0] imm, input logic [2:0] alu,
                                     input logic rw, input logic ill);
    return {pcw, adr, mw, irw, res, a, b, imm, alu, rw, ill};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  logic [17:0] F, D, Z;

  initial begin
    F = ev(1, 0, 0, 1, 2'd2, 2'd0, 2'd2, 3'd0, 3'd0, 0, 0);
    D = ev(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd2, 3'd0, 0, 0);
    Z = 18'd0;

    // reset held: everything low
    nxt(); chk("rst_idle", Z);
    nxt(); chk("rst_idle2", Z);

    // lw
    rst_n = 1'b1; op = 7'b0000011; funct3 = 3'b010; #1;
    chk("lw_fetch", F);
    nxt(); chk("lw_decode", D);
    nxt(); chk("lw_memadr", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0, 0));
    nxt(); chk("lw_memread", ev(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 0));
    nxt(); chk("lw_memwb", ev(0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 1, 0));

    // sw
    nxt(); op = 7'b0100011; #1; chk("sw_fetch", F);
    nxt(); chk("sw_decode", D);
    nxt(); chk("sw_memadr", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd1, 3'd0, 0, 0));
    nxt(); chk("sw_memwrite", ev(0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 0));

    // beq, taken then not taken within the BRANCH cycle
    nxt(); op = 7'b1100011; funct3 = 3'b000; #1; chk("beq_fetch", F);
    nxt(); chk("beq_decode", D);
    nxt(); zero = 1'b1; #1;
    chk("beq_taken", ev(1, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0, 0));
    zero = 1'b0; #1;
    chk("beq_not_taken", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0, 0));

    // R-type sub
    nxt(); op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; #1; chk("beq_ret_fetch", F);
    nxt(); chk("sub_decode", D);
    nxt(); chk("sub_execr", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0, 0));
    nxt(); chk("sub_aluwb", ev(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1, 0));

    // R-type or
    nxt(); funct3 = 3'b110; funct7b5 = 1'b0; #1; chk("or_fetch", F);
    nxt(); chk("or_decode", D);
    nxt(); chk("or_execr", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd3, 0, 0));
    nxt(); chk("or_aluwb", ev(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1, 0));

    // addi with funct7b5 set stays add
    nxt(); op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1; #1; chk("addi_fetch", F);
    nxt(); chk("addi_decode", D);
    nxt(); chk("addi_execi", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd0, 0, 0));
    nxt(); chk("addi_aluwb", ev(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1, 0));

    // slti and andi
    nxt(); funct3 = 3'b010; funct7b5 = 1'b0; #1; chk("slti_fetch", F);
    nxt(); nxt(); chk("slti_execi", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd5, 0, 0));
    nxt(); nxt(); funct3 = 3'b111; nxt(); nxt();
    chk("andi_execi", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 3'd2, 0, 0));

    // R-type with unsupported funct3: flagged, write suppressed
    nxt(); nxt(); op = 7'b0110011; funct3 = 3'b001; #1; chk("badf3_fetch", F);
    nxt(); chk("badf3_decode", D);
    nxt(); chk("badf3_execr", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd0, 0, 1));
    nxt(); chk("badf3_aluwb", Z);

    // jal
    nxt(); op = 7'b1101111; funct3 = 3'b101; #1; chk("jal_fetch", F);
    nxt(); chk("jal_decode", D);
    nxt(); chk("jal_jal", ev(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd3, 3'd0, 0, 0));
    nxt(); chk("jal_aluwb", ev(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1, 0));

    // lui
    nxt(); op = 7'b0110111; #1; chk("lui_fetch", F);
    nxt(); chk("lui_decode", D);
    nxt(); chk("lui_luiwb", ev(0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 3'd4, 3'd0, 1, 0));

    // unsupported opcode
    nxt(); op = 7'b1111111; #1; chk("ill_fetch", F);
    nxt(); chk("ill_decode", ev(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd2, 3'd0, 0, 1));
    nxt(); chk("ill_ret_fetch", F);

    // bne
    op = 7'b1100011; funct3 = 3'b001; zero = 1'b0;
    nxt(); chk("bne_decode", D);
    nxt();
`ifdef MC_BNE_EN
    chk("bne_z0", ev(1, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0, 0));
    zero = 1'b1; #1;
    chk("bne_z1", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0, 0));
`else
    chk("bne_z0", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0, 1));
    zero = 1'b1; #1;
    chk("bne_z1", ev(0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0, 3'd1, 0, 1));
`endif
    zero = 1'b0;

    // reset in the middle of lw
    nxt(); op = 7'b0000011; funct3 = 3'b010; #1; chk("rlw_fetch", F);
    nxt(); nxt(); nxt();
    chk("rlw_memread", ev(0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 0));
    rst_n = 1'b0; #1; chk("rlw_rst_low", Z);
    nxt(); chk("rlw_rst_held", Z);
    rst_n = 1'b1; #1; chk("rlw_restart_fetch", F);
    nxt(); chk("rlw_restart_decode", D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
